// File: rtl/axi_exdes_pkg.sv
// AXI4-Lite loopback example design: shared types and helpers.
// Expected-value functions are used by both the responder and the scoreboard.
package axi_exdes_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD      = 3'd3,
    S_RD_DATA = 3'd4,
    S_DONE    = 3'd5
  } mst_state_t;

  localparam logic [31:0] WDATA_SEED = 32'hA5A5_0000;

  // Byte address of transaction i; caller truncates to ADDR_W (wrap).
  function automatic logic [63:0] exp_addr(
    input logic [63:0] base,
    input logic [15:0] i
  );
    return base + {46'd0, i, 2'b00};
  endfunction

  function automatic logic [63:0] exp_wdata(input logic [15:0] i);
    return {32'd0, WDATA_SEED ^ {16'd0, i}};
  endfunction

  // Inverted address, limited to the low aw bits (zero above them).
  function automatic logic [63:0] exp_rdata(
    input logic [63:0] addr,
    input int unsigned aw
  );
    logic [63:0] mask;
    mask = (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
    return ~addr & mask;
  endfunction

endpackage

// File: rtl/axi_exdes_if.sv
// AXI4-Lite link between the loopback master engine and slave responder.
// Master modport drives requests; slave modport drives responses.
interface axi_exdes_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import axi_exdes_pkg::*;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;

  logic  bvalid;
  logic  bready;
  resp_t bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  resp_t             rresp;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi_exdes_slv_resp.sv
// Memoryless AXI4-Lite slave responder with external backpressure.
// Writes always answer OKAY; reads return the inverted read address.
module axi_exdes_slv_resp
  import axi_exdes_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        stall,
  axi_exdes_if.slave  s
);

  logic rdy;
  logic aw_got;
  logic w_got;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic unused_payload;

  assign rdy       = !stall && !areset;
  assign s.awready = rdy;
  assign s.wready  = rdy;
  assign s.arready = rdy;

  assign aw_hs = s.awvalid && rdy;
  assign w_hs  = s.wvalid && rdy;
  assign ar_hs = s.arvalid && rdy;

  assign unused_payload =
    ^{s.awaddr, s.awprot, s.wdata, s.wstrb, s.arprot};

  // Pair up AW and W, then post one B; hold B until accepted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      s.bvalid <= 1'b0;
      s.bresp  <= OKAY;
    end else begin
      if (s.bvalid && s.bready)
        s.bvalid <= 1'b0;
      if ((aw_got || aw_hs) && (w_got || w_hs) &&
          (!s.bvalid || s.bready)) begin
        s.bvalid <= 1'b1;
        s.bresp  <= OKAY;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else begin
        if (aw_hs)
          aw_got <= 1'b1;
        if (w_hs)
          w_got <= 1'b1;
      end
    end
  end

  // Answer each AR with ~ARADDR; hold R until accepted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s.rvalid <= 1'b0;
      s.rdata  <= '0;
      s.rresp  <= OKAY;
    end else begin
      if (s.rvalid && s.rready)
        s.rvalid <= 1'b0;
      if (ar_hs) begin
        s.rvalid <= 1'b1;
        s.rdata  <= DATA_W'(exp_rdata(64'(s.araddr), ADDR_W));
        s.rresp  <= OKAY;
      end
    end
  end

endmodule

// File: rtl/axi_exdes_loopback.sv
// AXI4-Lite loopback: write-then-read master, slave responder, scoreboard.
// The link leaves through mst/slv so the two sides are wired outside.
module axi_exdes_loopback
  import axi_exdes_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_TXN = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         start,
  input  logic         stall,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  wr_count,
  output logic [15:0]  rd_count,
  output logic [15:0]  err_count,
  axi_exdes_if.master  mst,
  axi_exdes_if.slave   slv
);

  localparam logic [15:0] LAST = 16'(NUM_TXN - 1);
  localparam logic [15:0] NTXN = 16'(NUM_TXN);
  localparam logic [63:0] BASE = 64'(BASE_ADDR);

  mst_state_t  state;
  logic [15:0] idx;
  logic        awv;
  logic        wv;
  logic        arv;
  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;
  logic        ar_hs;
  logic        r_hs;
  logic        launch;
  logic [2:0]  err_inc;
  logic [16:0] err_sum;

  axi_exdes_slv_resp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_slv (
    .aclk   (aclk),
    .areset (areset),
    .stall  (stall),
    .s      (slv)
  );

  assign mst.awvalid = awv;
  assign mst.awaddr  = ADDR_W'(exp_addr(BASE, idx));
  assign mst.awprot  = 3'd0;
  assign mst.wvalid  = wv;
  assign mst.wdata   = DATA_W'(exp_wdata(idx));
  assign mst.wstrb   = '1;
  assign mst.bready  = (state == S_WR_RESP);
  assign mst.arvalid = arv;
  assign mst.araddr  = ADDR_W'(exp_addr(BASE, idx));
  assign mst.arprot  = 3'd0;
  assign mst.rready  = (state == S_RD_DATA);

  assign aw_hs = mst.awvalid && mst.awready;
  assign w_hs  = mst.wvalid && mst.wready;
  assign b_hs  = mst.bvalid && mst.bready;
  assign ar_hs = mst.arvalid && mst.arready;
  assign r_hs  = mst.rvalid && mst.rready;

  assign launch = start &&
    (state == S_IDLE || state == S_DONE);

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == 16'd0);

  // Master engine: one outstanding write, then one outstanding read.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= S_IDLE;
      idx   <= '0;
      awv   <= 1'b0;
      wv    <= 1'b0;
      arv   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_WR;
            idx   <= '0;
            awv   <= 1'b1;
            wv    <= 1'b1;
          end
        end
        S_WR: begin
          if (aw_hs)
            awv <= 1'b0;
          if (w_hs)
            wv <= 1'b0;
          if ((!awv || mst.awready) && (!wv || mst.wready))
            state <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (b_hs) begin
            if (idx == LAST) begin
              idx   <= '0;
              arv   <= 1'b1;
              state <= S_RD;
            end else begin
              idx   <= idx + 16'd1;
              awv   <= 1'b1;
              wv    <= 1'b1;
              state <= S_WR;
            end
          end
        end
        S_RD: begin
          if (ar_hs) begin
            arv   <= 1'b0;
            state <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (r_hs) begin
            if (idx == LAST) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 16'd1;
              arv   <= 1'b1;
              state <= S_RD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Scoreboard: index comes from its own completion counters.
  always_comb begin
    err_inc = 3'd0;
    if (aw_hs && mst.awaddr != ADDR_W'(exp_addr(BASE, wr_count)))
      err_inc = err_inc + 3'd1;
    if (w_hs && mst.wdata != DATA_W'(exp_wdata(wr_count)))
      err_inc = err_inc + 3'd1;
    if (b_hs && mst.bresp != OKAY)
      err_inc = err_inc + 3'd1;
    if (r_hs && mst.rdata !=
        DATA_W'(exp_rdata(exp_addr(BASE, rd_count), ADDR_W)))
      err_inc = err_inc + 3'd1;
    if (r_hs && mst.rresp != OKAY)
      err_inc = err_inc + 3'd1;
    if (ar_hs && wr_count != NTXN)
      err_inc = err_inc + 3'd1;
  end

  assign err_sum = {1'b0, err_count} + 17'(err_inc);

  // Completion and error counters; a new run clears them.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_count  <= '0;
      rd_count  <= '0;
      err_count <= '0;
    end else if (launch) begin
      wr_count  <= '0;
      rd_count  <= '0;
      err_count <= '0;
    end else begin
      if (b_hs)
        wr_count <= wr_count + 16'd1;
      if (r_hs)
        rd_count <= rd_count + 16'd1;
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule

// File: tb/tb_axi_exdes_loopback.sv
// Directed bench for axi_exdes_loopback: timing, stall, fault, reset, wrap.
// DUT 1 runs through a bridge allowing RDATA corruption; DUT 2 tests wrap.
module tb_axi_exdes_loopback;
  import axi_exdes_pkg::*;

  logic        aclk;
  logic        areset;
  logic        start;
  logic        stall;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic [15:0] err_count;
  logic        inj;

  logic        start2;
  logic        stall2;
  logic        busy2;
  logic        done2;
  logic        pass2;
  logic [15:0] wr2;
  logic [15:0] rd2;
  logic [15:0] err2;

  int errors;
  int checks;

  axi_exdes_if m_if ();
  axi_exdes_if s_if ();
  axi_exdes_if lnk2 ();

  assign s_if.awvalid = m_if.awvalid;
  assign s_if.awaddr  = m_if.awaddr;
  assign s_if.awprot  = m_if.awprot;
  assign s_if.wvalid  = m_if.wvalid;
  assign s_if.wdata   = m_if.wdata;
  assign s_if.wstrb   = m_if.wstrb;
  assign s_if.bready  = m_if.bready;
  assign s_if.arvalid = m_if.arvalid;
  assign s_if.araddr  = m_if.araddr;
  assign s_if.arprot  = m_if.arprot;
  assign s_if.rready  = m_if.rready;
  assign m_if.awready = s_if.awready;
  assign m_if.wready  = s_if.wready;
  assign m_if.bvalid  = s_if.bvalid;
  assign m_if.bresp   = s_if.bresp;
  assign m_if.arready = s_if.arready;
  assign m_if.rvalid  = s_if.rvalid;
  assign m_if.rresp   = s_if.rresp;
  assign m_if.rdata   = s_if.rdata ^
    {31'd0, inj && (rd_count == 16'd2)};

  axi_exdes_loopback #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .NUM_TXN   (16),
    .BASE_ADDR (32'h0)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .start     (start),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .wr_count  (wr_count),
    .rd_count  (rd_count),
    .err_count (err_count),
    .mst       (m_if.master),
    .slv       (s_if.slave)
  );

  axi_exdes_loopback #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .NUM_TXN   (4),
    .BASE_ADDR (32'hFFFF_FFF8)
  ) dut2 (
    .aclk      (aclk),
    .areset    (areset),
    .start     (start2),
    .stall     (stall2),
    .busy      (busy2),
    .done      (done2),
    .pass      (pass2),
    .wr_count  (wr2),
    .rd_count  (rd2),
    .err_count (err2),
    .mst       (lnk2.master),
    .slv       (lnk2.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Pulse start for one sampling edge E; returns 1 ns after E.
  task automatic kick();
    @(negedge aclk);
    start = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    start  = 1'b0;
    stall  = 1'b0;
    inj    = 1'b0;
    start2 = 1'b0;
    stall2 = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {busy, done, pass});
    end
    checks++;
    if ({wr_count, rd_count, err_count} !== 48'd0) begin
      errors++;
      $display("FAIL reset_counts: got %h want 0",
        {wr_count, rd_count, err_count});
    end
    checks++;
    if ({m_if.awvalid, m_if.wvalid, m_if.arvalid,
         m_if.bready, m_if.rready, m_if.bvalid,
         m_if.rvalid} !== 7'd0) begin
      errors++;
      $display("FAIL reset_valids: got nonzero want 0");
    end
    checks++;
    if ({busy2, done2} !== 2'b00) begin
      errors++;
      $display("FAIL reset_dut2: got %b want 00", {busy2, done2});
    end
  endtask

  task automatic test_basic();
    int n;
    kick();
    checks++;
    if ({busy, m_if.awvalid, m_if.wvalid} !== 3'b111) begin
      errors++;
      $display("FAIL basic_launch: got %b want 111",
        {busy, m_if.awvalid, m_if.wvalid});
    end
    checks++;
    if (m_if.awaddr !== 32'h0 || m_if.wdata !== 32'hA5A5_0000) begin
      errors++;
      $display("FAIL basic_txn0: got %h/%h want 0/a5a50000",
        m_if.awaddr, m_if.wdata);
    end
    n = 0;
    while (!done && n < 300) begin
      @(posedge aclk);
      #1;
      n++;
      if (n == 2) begin
        checks++;
        if (wr_count !== 16'd1) begin
          errors++;
          $display("FAIL basic_wr1: got %0d want 1", wr_count);
        end
      end
    end
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL basic_edges: got %0d want 64", n);
    end
    checks++;
    if (wr_count !== 16'd16 || rd_count !== 16'd16) begin
      errors++;
      $display("FAIL basic_counts: got %0d/%0d want 16/16",
        wr_count, rd_count);
    end
    checks++;
    if (err_count !== 16'd0 || pass !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_pass: got err=%0d pass=%b busy=%b want 0/1/0",
        err_count, pass, busy);
    end
  endtask

  task automatic test_stall();
    int n;
    kick();
    n = 0;
    while (!done && n < 300) begin
      @(posedge aclk);
      #1;
      n++;
      if (n >= 10 && n <= 13) begin
        checks++;
        if (m_if.awvalid !== 1'b1 || m_if.wvalid !== 1'b1 ||
            m_if.awaddr !== 32'h14 ||
            m_if.wdata !== 32'hA5A5_0005) begin
          errors++;
          $display("FAIL stall_hold@%0d: got %b%b %h %h want 11 14 a5a50005",
            n, m_if.awvalid, m_if.wvalid, m_if.awaddr, m_if.wdata);
        end
      end
      stall = (n >= 10 && n <= 12);
    end
    stall = 1'b0;
    checks++;
    if (n !== 67) begin
      errors++;
      $display("FAIL stall_edges: got %0d want 67", n);
    end
    checks++;
    if (pass !== 1'b1 || wr_count !== 16'd16) begin
      errors++;
      $display("FAIL stall_pass: got pass=%b wr=%0d want 1/16",
        pass, wr_count);
    end
  endtask

  task automatic test_fault();
    int n;
    inj = 1'b1;
    kick();
    n = 0;
    while (!done && n < 300) begin
      @(posedge aclk);
      #1;
      n++;
    end
    inj = 1'b0;
    checks++;
    if (err_count !== 16'd1) begin
      errors++;
      $display("FAIL fault_err: got %0d want 1", err_count);
    end
    checks++;
    if (pass !== 1'b0 || done !== 1'b1 || rd_count !== 16'd16) begin
      errors++;
      $display("FAIL fault_flags: got pass=%b done=%b rd=%0d want 0/1/16",
        pass, done, rd_count);
    end
  endtask

  task automatic test_rerun();
    int n;
    kick();
    checks++;
    if (wr_count !== 16'd0 || rd_count !== 16'd0 ||
        err_count !== 16'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rerun_clear: got %0d/%0d/%0d busy=%b want 0/0/0/1",
        wr_count, rd_count, err_count, busy);
    end
    n = 0;
    while (!done && n < 300) begin
      @(posedge aclk);
      #1;
      n++;
    end
    checks++;
    if (n !== 64 || pass !== 1'b1) begin
      errors++;
      $display("FAIL rerun_pass: got edges=%0d pass=%b want 64/1", n, pass);
    end
  endtask

  task automatic test_areset();
    int n;
    kick();
    repeat (20) @(posedge aclk);
    #1;
    areset = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass} !== 3'b000 ||
        {wr_count, rd_count, err_count} !== 48'd0) begin
      errors++;
      $display("FAIL areset_outs: got %b %h want 000 0",
        {busy, done, pass}, {wr_count, rd_count, err_count});
    end
    checks++;
    if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bvalid,
         m_if.rvalid, m_if.bready, m_if.rready} !== 7'd0) begin
      errors++;
      $display("FAIL areset_link: got nonzero want 0");
    end
    @(negedge aclk);
    areset = 1'b0;
    kick();
    n = 0;
    while (!done && n < 300) begin
      @(posedge aclk);
      #1;
      n++;
    end
    checks++;
    if (n !== 64 || pass !== 1'b1) begin
      errors++;
      $display("FAIL areset_rerun: got edges=%0d pass=%b want 64/1",
        n, pass);
    end
  endtask

  task automatic test_start_busy();
    int n;
    kick();
    n = 0;
    while (!done && n < 300) begin
      @(posedge aclk);
      #1;
      n++;
      start = (n == 9 || n == 29);
    end
    start = 1'b0;
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL busy_start_edges: got %0d want 64", n);
    end
    checks++;
    if (wr_count !== 16'd16 || rd_count !== 16'd16 || pass !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_pass: got %0d/%0d pass=%b want 16/16/1",
        wr_count, rd_count, pass);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [4];
    logic [31:0] got [4];
    int k;
    int n;
    want = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    got  = '{default: '0};
    k = 0;
    @(negedge aclk);
    start2 = 1'b1;
    @(posedge aclk);
    #1;
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 100) begin
      @(negedge aclk);
      if (lnk2.awvalid && lnk2.awready && k < 4) begin
        got[k] = lnk2.awaddr;
        k++;
      end
      @(posedge aclk);
      #1;
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++;
        $display("FAIL wrap_addr%0d: got %h want %h", i, got[i], want[i]);
      end
    end
    checks++;
    if (n !== 16 || pass2 !== 1'b1 || rd2 !== 16'd4) begin
      errors++;
      $display("FAIL wrap_pass: got edges=%0d pass=%b rd=%0d want 16/1/4",
        n, pass2, rd2);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_stall();
    test_fault();
    test_rerun();
    test_areset();
    test_start_busy();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_exdes_loopback.md
# axi_exdes_loopback

Self-checking AXI4-Lite traffic loopback for the VIP example design: a master engine issues a fixed write-then-read sequence, a memoryless slave responder answers it, and a pass-through monitor/scoreboard checks every transaction. It replaces the three simulation-only example components (master stimulus, slave stimulus, generic scoreboard) with one synthesizable block. Results are reported on status ports.

## Interface
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width (multiple of 8)
- NUM_TXN, 16, writes per run (same number of reads follow), 1..65535
- BASE_ADDR, 0, address of transaction 0
- aclk  in  1  clock
- areset  in  1  reset; asynchronous and active-high
- start  in  1  one-cycle run request; ignored while busy
- stall  in  1  slave backpressure: while 1, all slave READY outputs are 0
- busy  out  1  run in progress
- done  out  1  run finished; held until the next start or reset
- pass  out  1  done and err_count==0
- wr_count  out  16  completed write responses
- rd_count  out  16  completed read responses
- err_count  out  16  scoreboard mismatches, saturating at 16'hFFFF

## Operation
- Transaction i (0..NUM_TXN-1): addr = BASE_ADDR + 4*i (ADDR_W wrap-around), wdata = 32'hA5A5_0000 ^ i (zero-extended), WSTRB all ones, PROT 0.
- Master states: IDLE -> WR (AW and W valid together) -> WR_RESP -> back to WR, or RD after the last write -> RD_DATA -> back to RD, or DONE after the last read. In DONE, start re-enters WR and clears all counters. One outstanding transaction at a time.
- Master BREADY and RREADY are 1 in WR_RESP and RD_DATA.
- Master deasserts AWVALID and WVALID independently as each channel handshakes. It leaves WR only when both channels are done.
- Slave responder has no memory:
  - AWREADY = WREADY = ARREADY = !stall.
  - Captures AW and W independently.
  - Raises BVALID (BRESP=OKAY) on the edge after both are captured.
  - Raises RVALID on the edge after the AR handshake, with RDATA = ~ARADDR (zero-extended or truncated to DATA_W) and RRESP=OKAY.
  - Holds BVALID and RVALID until accepted.
- Monitor/scoreboard taps the internal link and counts one error for each of these:
  - captured AWADDR/WDATA differs from the expected value for index i
  - BRESP != OKAY
  - RDATA != ~expected address
  - RRESP != OKAY
  - an AR handshake occurs while writes remain
- All VALID signals stay stable, with payload unchanged, until READY.

## Timing
- Reset values: busy=0, done=0, pass=0, all counts 0, all VALID and READY outputs 0, state IDLE.
- start sampled at edge E: busy=1 and AWVALID=WVALID=1 after E.
- With stall=0, each write takes 2 edges (handshake, then B) and each read takes 2 edges (AR, then R).
- done rises after edge E+4*NUM_TXN; busy falls on the same edge.
- Each cycle of stall=1 adds exactly one cycle of delay per stalled handshake. B and R are never delayed by stall.
- Counters increment on the B and R handshake edges.
- An areset assertion mid-run immediately returns every register to its reset value; outstanding transactions are dropped.
- start while busy is ignored. start in the same cycle as areset is ignored.

## Structure
- Package axi_exdes_pkg holds:
  - resp_t enum (OKAY=2'b00, EXOKAY, SLVERR, DECERR)
  - master state enum
  - functions exp_addr(i), exp_wdata(i), exp_rdata(addr)
- Sub-module axi_exdes_slv_resp (slave responder with stall input).
- Master FSM and scoreboard live in the top level.

## Test plan
- Reset then start with NUM_TXN=16, stall=0 -> done after exactly 64 edges; wr_count=16, rd_count=16, err_count=0, pass=1.
- stall=1 for 3 cycles during write 5 -> done is delayed by exactly 3 cycles; AWADDR=0x14 and WDATA=0xA5A5_0005 are held stable throughout; pass=1.
- Force RDATA bit 0 flipped on read 2 (bench fault injection) -> err_count=1, pass=0, done=1.
- areset pulse at edge 20 -> all outputs 0 immediately; a new start completes normally with pass=1.
- Pulse start at edges 10 and 30 of a run -> sequence unaffected; a start in DONE clears counters and reruns to pass=1.
- BASE_ADDR=32'hFFFF_FFF8, NUM_TXN=4 -> addresses FFFF_FFF8, FFFF_FFFC, 0, 4 with wrap; pass=1.
